pll_rst_ctrl: RTL and testbench

PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

---
 rtl/pll_rst_ctrl.sv | 150 +++++++++++++++
 tb/tb_pll_rst_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases downstream domain resets one by one and watches for lock loss.
module pll_rst_ctrl #(
    parameter int RST_HOLD_CYC     = 100,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 1000000,
    parameter int RELEASE_GAP_CYC  = 16,
    parameter int N_DOM            = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pll_lock,
    input  logic             soft_rst_req,
    output logic             pll_rst,
    output logic [N_DOM-1:0] rst_n_out,
    output logic             ready,
    output logic             timeout_err,
    output logic [7:0]       lock_lost_cnt,
    output logic [1:0]       state_dbg
);

    localparam int HOLD_W   = $clog2(RST_HOLD_CYC + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TO_W     = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int GAP_W    = $clog2(RELEASE_GAP_CYC + 1);

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(RELEASE_GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t              state;
    logic                lock_meta;
    logic                lock_s;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STABLE_W-1:0] stable_cnt;
    logic [TO_W-1:0]     timeout_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [N_DOM-1:0]    rel_next;
    logic                lock_loss;
    logic                timeout_hit;

    assign state_dbg = state;

    // Domain releases form a thermometer code growing from bit 0.
    assign rel_next    = (rst_n_out << 1) | N_DOM'(1);
    assign lock_loss   = !lock_s && (state == S_RELEASE || state == S_RUN);
    assign timeout_hit = (state == S_WAIT_LOCK) && (timeout_cnt == TO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_RESET_PLL;
            pll_rst       <= 1'b1;
            rst_n_out     <= '0;
            ready         <= 1'b0;
            timeout_err   <= 1'b0;
            lock_lost_cnt <= 8'd0;
            hold_cnt      <= '0;
            stable_cnt    <= '0;
            timeout_cnt   <= '0;
            gap_cnt       <= '0;
        end else if (soft_rst_req || lock_loss || timeout_hit) begin
            // Every path back to RESET_PLL restarts the hold window from zero.
            state       <= S_RESET_PLL;
            pll_rst     <= 1'b1;
            rst_n_out   <= '0;
            ready       <= 1'b0;
            hold_cnt    <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            gap_cnt     <= '0;
            if (!soft_rst_req && lock_loss) begin
                if (lock_lost_cnt != 8'hFF) begin
                    lock_lost_cnt <= lock_lost_cnt + 8'd1;
                end
            end else if (!soft_rst_req && timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= S_WAIT_LOCK;
                        pll_rst     <= 1'b0;
                        hold_cnt    <= '0;
                        stable_cnt  <= '0;
                        timeout_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (!lock_s) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        stable_cnt <= '0;
                        gap_cnt    <= '0;
                        rst_n_out  <= N_DOM'(1);
                        if (N_DOM == 1) begin
                            state <= S_RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        rst_n_out <= rel_next;
                        if (&rel_next) begin
                            state <= S_RUN;
                            ready <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state   <= S_RESET_PLL;
                    pll_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl with small parameters; all timings counted by hand
// from the edge on which the stimulus is applied.
module tb_pll_rst_ctrl;

    localparam int N_DOM = 3;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             pll_lock;
    logic             soft_rst_req;
    logic             pll_rst;
    logic [N_DOM-1:0] rst_n_out;
    logic             ready;
    logic             timeout_err;
    logic [7:0]       lock_lost_cnt;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    pll_rst_ctrl #(
        .RST_HOLD_CYC    (4),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT_CYC(64),
        .RELEASE_GAP_CYC (2),
        .N_DOM           (N_DOM)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .rst_n_out    (rst_n_out),
        .ready        (ready),
        .timeout_err  (timeout_err),
        .lock_lost_cnt(lock_lost_cnt),
        .state_dbg    (state_dbg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_release(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        chk(tag, 32'(rst_n_out), e);
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h7);

        // Reset values
        tick(3);
        chk("rst_pll_rst", 32'(pll_rst), 32'h1);
        chk("rst_rst_n_out", 32'(rst_n_out), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_lock_lost", 32'(lock_lost_cnt), 32'h0);
        sys_rst_n = 1'b1;

        // Hold window, then lock arriving right after pll_rst falls: 2 sync + 8 stable
        tick(3);
        chk("hold_still_high", 32'(pll_rst), 32'h1);
        tick(1);
        chk("hold_falls", 32'(pll_rst), 32'h0);
        pll_lock = 1'b1;
        tick(9);
        chk("dom0_not_yet", 32'(rst_n_out), 32'h0);
        tick(1);
        chk_release("dom0_rise");
        chk("ready_low_dom0", 32'(ready), 32'h0);
        tick(1);
        chk("dom1_not_yet", 32'(rst_n_out), 32'h1);
        tick(1);
        chk_release("dom1_rise");
        tick(2);
        chk_release("dom2_rise");
        chk("ready_high", 32'(ready), 32'h1);
        chk("no_loss_yet", 32'(lock_lost_cnt), 32'h0);

        // Lock loss in RUN: visible 3 cycles after the drop
        pll_lock = 1'b0;
        tick(2);
        chk("loss_not_yet", 32'(rst_n_out), 32'h7);
        tick(1);
        chk("loss_doms", 32'(rst_n_out), 32'h0);
        chk("loss_ready", 32'(ready), 32'h0);
        chk("loss_pll_rst", 32'(pll_rst), 32'h1);
        chk("loss_cnt1", 32'(lock_lost_cnt), 32'h1);

        // Lock stays low: PLL re-reset every 4+64 cycles, sticky timeout flag
        tick(3);
        chk("to_hold_high", 32'(pll_rst), 32'h1);
        tick(1);
        chk("to_hold_falls", 32'(pll_rst), 32'h0);
        tick(63);
        chk("to_before", 32'(pll_rst), 32'h0);
        chk("to_err_before", 32'(timeout_err), 32'h0);
        tick(1);
        chk("to_repulse1", 32'(pll_rst), 32'h1);
        chk("to_err_set", 32'(timeout_err), 32'h1);
        tick(3);
        chk("to_hold2_high", 32'(pll_rst), 32'h1);
        tick(1);
        chk("to_hold2_falls", 32'(pll_rst), 32'h0);
        tick(63);
        chk("to_before2", 32'(pll_rst), 32'h0);
        tick(1);
        chk("to_repulse2", 32'(pll_rst), 32'h1);
        chk("to_no_loss_count", 32'(lock_lost_cnt), 32'h1);

        // Soft request two cycles into the hold window restarts the hold
        tick(2);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        tick(1);
        chk("soft_hold_ext_a", 32'(pll_rst), 32'h1);
        tick(2);
        chk("soft_hold_ext_b", 32'(pll_rst), 32'h1);
        tick(1);
        chk("soft_hold_falls", 32'(pll_rst), 32'h0);

        // One-cycle lock glitch at stable count 5 restarts the stable count
        pll_lock = 1'b1;
        tick(7);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(9);
        chk("glitch_dom0_late", 32'(rst_n_out), 32'h0);
        tick(1);
        chk("glitch_dom0_rise", 32'(rst_n_out), 32'h1);
        chk("glitch_no_loss", 32'(lock_lost_cnt), 32'h1);

        // Lock loss coinciding with a soft request in RELEASE: soft wins, no count
        pll_lock = 1'b0;
        tick(2);
        chk("rel_dom1", 32'(rst_n_out), 32'h3);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        chk("soft_loss_doms", 32'(rst_n_out), 32'h0);
        chk("soft_loss_ready", 32'(ready), 32'h0);
        chk("soft_loss_pll_rst", 32'(pll_rst), 32'h1);
        chk("soft_loss_cnt", 32'(lock_lost_cnt), 32'h1);

        // Constant lock after re-reset: 8 stable cycles; timeout flag stays set
        pll_lock = 1'b1;
        tick(4);
        chk("relock_hold_falls", 32'(pll_rst), 32'h0);
        tick(8);
        chk("relock_dom0", 32'(rst_n_out), 32'h1);
        tick(4);
        chk("relock_all", 32'(rst_n_out), 32'h7);
        chk("relock_ready", 32'(ready), 32'h1);
        chk("to_err_sticky", 32'(timeout_err), 32'h1);

        // 300 lock drops from RUN: counter saturates at 255
        for (int i = 1; i <= 300; i++) begin
            pll_lock = 1'b0;
            tick(3);
            if (i == 253) chk("sat_254", 32'(lock_lost_cnt), 32'd254);
            if (i == 254) chk("sat_255", 32'(lock_lost_cnt), 32'd255);
            pll_lock = 1'b1;
            tick(16);
            chk("loop_ready", 32'(ready), 32'h1);
        end
        chk("sat_final", 32'(lock_lost_cnt), 32'd255);

        // Asynchronous reset mid-run overrides everything immediately
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_pll_rst", 32'(pll_rst), 32'h1);
        chk("async_doms", 32'(rst_n_out), 32'h0);
        chk("async_ready", 32'(ready), 32'h0);
        chk("async_to_err", 32'(timeout_err), 32'h0);
        chk("async_lock_lost", 32'(lock_lost_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
